// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: holds issued ops until both operands
// are present (captured from the CDB), then dispatches the lowest-index ready one.
`timescale 1ns/1ps
module alu_rs #(
  parameter int ENTRIES = 4,
  parameter int TAG_W = 5,
  parameter int DATA_W = 32,
  parameter int OP_W = 4,
  parameter logic [TAG_W-1:0] NO_TAG = {1'b1, {(TAG_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_dest,
  input  logic [TAG_W-1:0]  issue_q1,
  input  logic [DATA_W-1:0] issue_v1,
  input  logic [TAG_W-1:0]  issue_q2,
  input  logic [DATA_W-1:0] issue_v2,
  output logic              rs_full,
  input  logic              cdb_done,
  input  logic [TAG_W-1:0]  cdb_index,
  input  logic [DATA_W-1:0] cdb_result,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [TAG_W-1:0]  alu_dest
);
  localparam int IDX_W = $clog2(ENTRIES);

  // Handshake: a dispatched op is transferred on a rising edge where alu_valid
  // and alu_ready are both high; while alu_valid && !alu_ready the output
  // register holds every field stable and no new op is selected.

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q   [ENTRIES];
  logic [OP_W-1:0]    op_d   [ENTRIES];
  logic [TAG_W-1:0]   dest_q [ENTRIES];
  logic [TAG_W-1:0]   dest_d [ENTRIES];
  logic [TAG_W-1:0]   q1_q   [ENTRIES];
  logic [TAG_W-1:0]   q1_d   [ENTRIES];
  logic [TAG_W-1:0]   q2_q   [ENTRIES];
  logic [TAG_W-1:0]   q2_d   [ENTRIES];
  logic [DATA_W-1:0]  v1_q   [ENTRIES];
  logic [DATA_W-1:0]  v1_d   [ENTRIES];
  logic [DATA_W-1:0]  v2_q   [ENTRIES];
  logic [DATA_W-1:0]  v2_d   [ENTRIES];

  logic              alu_valid_q, alu_valid_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [TAG_W-1:0]  alu_dest_q, alu_dest_d;

  logic [ENTRIES-1:0] ready_vec;
  logic               free_found, rdy_found, cdb_hit, stall;
  logic [IDX_W-1:0]   free_idx, rdy_idx;

  assign rs_full = &busy_q;
  assign cdb_hit = cdb_done && (cdb_index != NO_TAG);
  assign stall   = alu_valid_q && !alu_ready;

  always_comb begin
    ready_vec  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready_vec[IDX_W'(i)] = busy_q[IDX_W'(i)] && (q1_q[IDX_W'(i)] == NO_TAG) &&
                             (q2_q[IDX_W'(i)] == NO_TAG);
      if (!busy_q[IDX_W'(i)] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready_vec[IDX_W'(i)] && !rdy_found) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d      = busy_q;
    op_d        = op_q;
    dest_d      = dest_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    alu_valid_d = alu_valid_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_dest_d  = alu_dest_q;

    // Wakeup only touches busy slots, so it never collides with the issue slot.
    if (cdb_hit) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_q[IDX_W'(i)] && (q1_q[IDX_W'(i)] == cdb_index)) begin
          q1_d[IDX_W'(i)] = NO_TAG;
          v1_d[IDX_W'(i)] = cdb_result;
        end
        if (busy_q[IDX_W'(i)] && (q2_q[IDX_W'(i)] == cdb_index)) begin
          q2_d[IDX_W'(i)] = NO_TAG;
          v2_d[IDX_W'(i)] = cdb_result;
        end
      end
    end

    if (issue_valid && free_found) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = issue_op;
      dest_d[free_idx] = issue_dest;
      q1_d[free_idx]   = issue_q1;
      v1_d[free_idx]   = issue_v1;
      q2_d[free_idx]   = issue_q2;
      v2_d[free_idx]   = issue_v2;
      // Tag being broadcast right now would otherwise never be seen again.
      if (cdb_hit && (issue_q1 == cdb_index)) begin
        q1_d[free_idx] = NO_TAG;
        v1_d[free_idx] = cdb_result;
      end
      if (cdb_hit && (issue_q2 == cdb_index)) begin
        q2_d[free_idx] = NO_TAG;
        v2_d[free_idx] = cdb_result;
      end
    end

    if (!stall) begin
      if (rdy_found) begin
        alu_valid_d     = 1'b1;
        alu_op_d        = op_q[rdy_idx];
        alu_a_d         = v1_q[rdy_idx];
        alu_b_d         = v2_q[rdy_idx];
        alu_dest_d      = dest_q[rdy_idx];
        busy_d[rdy_idx] = 1'b0;
      end else begin
        alu_valid_d = 1'b0;
      end
    end

    if (flush) begin
      busy_d      = '0;
      alu_valid_d = 1'b0;
      alu_op_d    = '0;
      alu_a_d     = '0;
      alu_b_d     = '0;
      alu_dest_d  = NO_TAG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_dest_q  <= NO_TAG;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[IDX_W'(i)]   <= '0;
        dest_q[IDX_W'(i)] <= NO_TAG;
        q1_q[IDX_W'(i)]   <= NO_TAG;
        q2_q[IDX_W'(i)]   <= NO_TAG;
        v1_q[IDX_W'(i)]   <= '0;
        v2_q[IDX_W'(i)]   <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_dest_q  <= alu_dest_d;
      op_q        <= op_d;
      dest_q      <= dest_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_dest  = alu_dest_q;

endmodule
